cv32e40x_rf_write_scheduler: RTL and testbench

//   Schedules register-file writes from two sources onto the two RF write ports
//   of cv32e40x_register_file_wrapper: the in-order WB stage, which has priority
//   and is never delayed, and X-interface coprocessor results, which are buffered
//   in a small FIFO and drained into free ports. Publishes a pending-rd scoreboard
//   to decode and forces a one-cycle WB stall when a buffered result is starved.

---
 rtl/cv32e40x_rf_write_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_cv32e40x_rf_write_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_rf_write_scheduler.sv
// cv32e40x_rf_write_scheduler
// Merges in-order WB register writes and buffered X-interface coprocessor
// results onto the two register-file write ports. WB always wins and is never
// delayed; X results wait in a small FIFO and drain into whatever ports WB
// leaves free. A pending-rd vector tells decode which registers still have an
// X result in flight, and a starvation counter forces a one-cycle WB stall when
// the FIFO head has been waiting too long.
module cv32e40x_rf_write_scheduler #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  // WB stage
  input  logic        wb_we_i,
  input  logic        wb_dual_i,
  input  logic [9:0]  wb_waddr_i,     // [4:0] = addr0, [9:5] = addr1
  input  logic [63:0] wb_wdata_i,     // [31:0] = data0, [63:32] = data1
  output logic        wb_stall_o,

  // X-interface result
  input  logic        xres_valid_i,
  output logic        xres_ready_o,
  input  logic        xres_we_i,
  input  logic        xres_dual_i,
  input  logic [4:0]  xres_rd_i,
  input  logic [63:0] xres_data_i,    // [31:0] = data0, [63:32] = data1

  // Register file write ports
  output logic [1:0]  rf_we_o,
  output logic [9:0]  rf_waddr_o,     // [4:0] = port0, [9:5] = port1
  output logic [63:0] rf_wdata_o,     // [31:0] = port0, [63:32] = port1
  output logic        rf_dualwrite_o,

  // Scoreboard to decode
  output logic [31:0] pending_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

  // FIFO storage; only the valid bits need a reset value
  logic [4:0]            ent_rd_q   [FIFO_DEPTH];
  logic                  ent_dual_q [FIFO_DEPTH];
  logic [63:0]           ent_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld_q, ent_vld_d;

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WW-1:0]         wait_q, wait_d;

  // Head of FIFO
  logic                  head_valid;
  logic [4:0]            head_rd;
  logic                  head_dual;
  logic [63:0]           head_data;

  // Port budgeting
  logic [1:0]            wb_used;
  logic [1:0]            free_ports;
  logic [1:0]            head_need;
  logic                  drain;

  // Push side
  logic                  accept;
  logic                  push;
  logic [4:0]            push_rd;

  logic [31:0]           pend_raw;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return ptr + PW'(1);
  endfunction

  assign head_valid = !rst && (count_q != '0);
  assign head_rd    = ent_rd_q[rd_ptr_q];
  assign head_dual  = ent_dual_q[rd_ptr_q];
  assign head_data  = ent_data_q[rd_ptr_q];

  assign xres_ready_o = !rst && (count_q < CW'(FIFO_DEPTH));
  assign accept       = xres_valid_i && xres_ready_o;
  assign push         = accept && xres_we_i;
  // A dual result always targets an even/odd pair starting at an even rd
  assign push_rd      = xres_dual_i ? {xres_rd_i[4:1], 1'b0} : xres_rd_i;

  assign wb_stall_o     = head_valid && (wait_q == WW'(STARVE_LIMIT));
  assign rf_dualwrite_o = rf_we_o[1];

  // Work out how many ports WB leaves free and whether the head fits
  always_comb begin
    wb_used = 2'd0;
    if (wb_we_i) begin
      wb_used = wb_dual_i ? 2'd2 : 2'd1;
    end
    free_ports = 2'd2 - wb_used;
    head_need  = head_dual ? 2'd2 : 2'd1;
    drain      = head_valid && (head_need <= free_ports);
  end

  // Write-port mux: WB first, then the drained FIFO head into the gaps
  always_comb begin
    rf_we_o    = '0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;

    if (wb_we_i) begin
      rf_we_o[0]        = 1'b1;
      rf_waddr_o[4:0]   = wb_waddr_i[4:0];
      rf_wdata_o[31:0]  = wb_wdata_i[31:0];
      if (wb_dual_i) begin
        rf_we_o[1]        = 1'b1;
        rf_waddr_o[9:5]   = wb_waddr_i[9:5];
        rf_wdata_o[63:32] = wb_wdata_i[63:32];
      end
    end

    if (drain) begin
      if (head_dual) begin
        rf_we_o[0]        = (head_rd != 5'd0);
        rf_waddr_o[4:0]   = head_rd;
        rf_wdata_o[31:0]  = head_data[31:0];
        rf_we_o[1]        = 1'b1;
        rf_waddr_o[9:5]   = head_rd | 5'd1;
        rf_wdata_o[63:32] = head_data[63:32];
      end else if (wb_we_i) begin
        rf_we_o[1]        = (head_rd != 5'd0);
        rf_waddr_o[9:5]   = head_rd;
        rf_wdata_o[63:32] = head_data[31:0];
      end else begin
        rf_we_o[0]        = (head_rd != 5'd0);
        rf_waddr_o[4:0]   = head_rd;
        rf_wdata_o[31:0]  = head_data[31:0];
      end
    end
  end

  // Pending-rd scoreboard built from every valid FIFO entry
  always_comb begin
    pend_raw = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld_q[i]) begin
        pend_raw = pend_raw | (32'd1 << ent_rd_q[i]);
        if (ent_dual_q[i]) begin
          pend_raw = pend_raw | (32'd1 << (ent_rd_q[i] | 5'd1));
        end
      end
    end
    pending_o = rst ? '0 : {pend_raw[31:1], 1'b0};
  end

  // FIFO pointer/count/valid next state and starvation counter
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ent_vld_d = ent_vld_q;
    wait_d    = wait_q;

    if (drain) begin
      rd_ptr_d            = ptr_inc(rd_ptr_q);
      ent_vld_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d            = ptr_inc(wr_ptr_q);
      ent_vld_d[wr_ptr_q] = 1'b1;
    end

    unique case ({push, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (!head_valid || drain) begin
      wait_d = '0;
    end else if (wait_q != WW'(STARVE_LIMIT)) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ent_vld_q <= '0;
      wait_q    <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ent_vld_q <= ent_vld_d;
      wait_q    <= wait_d;
    end
  end

  // Entry payload capture on push; validity is tracked separately
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= push_rd;
      ent_dual_q[wr_ptr_q] <= xres_dual_i;
      ent_data_q[wr_ptr_q] <= xres_data_i;
    end
  end

`ifndef SYNTHESIS
  // Interface contract held by the surrounding pipeline
  a_no_wb_in_stall : assert property (@(posedge clk) disable iff (rst)
    wb_stall_o |-> !wb_we_i);

  a_xres_stable : assert property (@(posedge clk) disable iff (rst)
    (xres_valid_i && !xres_ready_o) |=>
      (xres_valid_i && $stable(xres_we_i) && $stable(xres_dual_i) &&
       $stable(xres_rd_i) && $stable(xres_data_i)));

  a_wb_no_collision : assert property (@(posedge clk) disable iff (rst)
    wb_we_i |-> (!pending_o[wb_waddr_i[4:0]] &&
                 !(wb_dual_i && pending_o[wb_waddr_i[9:5]])));
`endif

endmodule

// File: tb/tb_cv32e40x_rf_write_scheduler.sv
// Directed bench for cv32e40x_rf_write_scheduler with hand-computed expectations.
module tb_cv32e40x_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, wb_dual;
  logic [9:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        wb_stall;
  logic        xv, xready, xwe, xdual;
  logic [4:0]  xrd;
  logic [63:0] xdata;
  logic [1:0]  rf_we;
  logic [9:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        rf_dual;
  logic [31:0] pending;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  cv32e40x_rf_write_scheduler #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_we_i        (wb_we),
    .wb_dual_i      (wb_dual),
    .wb_waddr_i     (wb_waddr),
    .wb_wdata_i     (wb_wdata),
    .wb_stall_o     (wb_stall),
    .xres_valid_i   (xv),
    .xres_ready_o   (xready),
    .xres_we_i      (xwe),
    .xres_dual_i    (xdual),
    .xres_rd_i      (xrd),
    .xres_data_i    (xdata),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .rf_dualwrite_o (rf_dual),
    .pending_o      (pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic setwb(input logic we, input logic dual, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    wb_we    = we;
    wb_dual  = dual;
    wb_waddr = {a1, a0};
    wb_wdata = {d1, d0};
  endtask

  task automatic setx(input logic v, input logic we, input logic dual, input logic [4:0] rd,
                      input logic [31:0] d0, input logic [31:0] d1);
    xv    = v;
    xwe   = we;
    xdual = dual;
    xrd   = rd;
    xdata = {d1, d0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    setwb(1'b1, 1'b0, 5'd3, 5'd0, 32'h55, 32'h0);
    setx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("rst_ready",   64'(xready),   64'd0);
    chk("rst_stall",   64'(wb_stall), 64'd0);
    chk("rst_pending", 64'(pending),  64'd0);
    chk("rst_we_wb",   64'(rf_we),    64'd1);
    chk("rst_addr_wb", 64'(rf_waddr[4:0]), 64'd3);
    next();
    next();
    rst = 1'b0;
    setwb(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("post_rst_ready",   64'(xready),  64'd1);
    chk("post_rst_pending", 64'(pending), 64'd0);
    chk("post_rst_we",      64'(rf_we),   64'd0);

    // ---------------- 1: single push, WB idle ----------------
    setx(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    settle();
    chk("t1_we_c0", 64'(rf_we), 64'd0);
    next();
    setx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t1_we_c1",    64'(rf_we),            64'd1);
    chk("t1_addr_c1",  64'(rf_waddr[4:0]),    64'd5);
    chk("t1_data_c1",  64'(rf_wdata[31:0]),   64'hDEAD_BEEF);
    chk("t1_pend_c1",  64'(pending),          64'h20);
    chk("t1_dual_c1",  64'(rf_dual),          64'd0);
    next();
    settle();
    chk("t1_pend_c2",  64'(pending), 64'd0);
    chk("t1_we_c2",    64'(rf_we),   64'd0);
    next();

    // ---------------- 2: WB single, head single -> port1 ----------------
    setwb(1'b1, 1'b0, 5'd3, 5'd0, 32'h1111, 32'h0);
    setx(1'b1, 1'b1, 1'b0, 5'd7, 32'h7777, 32'h0);
    settle();
    chk("t2_we_c0", 64'(rf_we), 64'd1);
    next();
    setx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t2_we_c1",   64'(rf_we),    64'd3);
    chk("t2_addr_c1", 64'(rf_waddr), 64'({5'd7, 5'd3}));
    chk("t2_data_c1", rf_wdata,      {32'h7777, 32'h1111});
    chk("t2_dw_c1",   64'(rf_dual),  64'd1);
    chk("t2_pend_c1", 64'(pending),  64'h80);
    next();
    settle();
    chk("t2_we_c2",   64'(rf_we),   64'd1);
    chk("t2_pend_c2", 64'(pending), 64'd0);
    next();

    // ---------------- 3: starvation under dual WB ----------------
    setwb(1'b1, 1'b1, 5'd2, 5'd3, 32'h2222, 32'h3333);
    setx(1'b1, 1'b1, 1'b0, 5'd12, 32'hC0C0, 32'h0);
    settle();
    chk("t3_stall_c0", 64'(wb_stall), 64'd0);
    next();
    setx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk($sformatf("t3_stall_c%0d", c), 64'(wb_stall), 64'd0);
      chk($sformatf("t3_we_c%0d", c),    64'(rf_we),    64'd3);
      next();
    end
    setwb(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t3_stall_c5", 64'(wb_stall),        64'd1);
    chk("t3_we_c5",    64'(rf_we),           64'd1);
    chk("t3_addr_c5",  64'(rf_waddr[4:0]),   64'd12);
    chk("t3_data_c5",  64'(rf_wdata[31:0]),  64'hC0C0);
    next();
    setwb(1'b1, 1'b1, 5'd2, 5'd3, 32'h2222, 32'h3333);
    settle();
    chk("t3_stall_c6", 64'(wb_stall), 64'd0);
    chk("t3_pend_c6",  64'(pending),  64'd0);
    chk("t3_we_c6",    64'(rf_we),    64'd3);
    next();

    // ---------------- 4: back-pressure with FIFO_DEPTH=2 ----------------
    setx(1'b1, 1'b1, 1'b0, 5'd10, 32'hA, 32'h0);
    settle();
    chk("t4_ready_c0", 64'(xready), 64'd1);
    next();
    setx(1'b1, 1'b1, 1'b0, 5'd11, 32'hB, 32'h0);
    settle();
    chk("t4_ready_c1", 64'(xready), 64'd1);
    next();
    setx(1'b1, 1'b1, 1'b0, 5'd13, 32'hC, 32'h0);
    settle();
    chk("t4_ready_c2", 64'(xready),  64'd0);
    chk("t4_pend_c2",  64'(pending), 64'h0C00);
    next();
    settle();
    chk("t4_ready_c3", 64'(xready), 64'd0);
    next();
    settle();
    chk("t4_ready_c4", 64'(xready),   64'd0);
    chk("t4_stall_c4", 64'(wb_stall), 64'd0);
    next();
    setwb(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t4_stall_c5", 64'(wb_stall),      64'd1);
    chk("t4_ready_c5", 64'(xready),        64'd0);
    chk("t4_we_c5",    64'(rf_we),         64'd1);
    chk("t4_addr_c5",  64'(rf_waddr[4:0]), 64'd10);
    next();
    setwb(1'b1, 1'b1, 5'd2, 5'd3, 32'h2222, 32'h3333);
    settle();
    chk("t4_stall_c6", 64'(wb_stall), 64'd0);
    chk("t4_ready_c6", 64'(xready),   64'd1);
    chk("t4_pend_c6",  64'(pending),  64'h0800);
    next();
    setwb(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    setx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t4_ready_c7", 64'(xready),        64'd0);
    chk("t4_pend_c7",  64'(pending),       64'h2800);
    chk("t4_we_c7",    64'(rf_we),         64'd1);
    chk("t4_addr_c7",  64'(rf_waddr[4:0]), 64'd11);
    next();
    settle();
    chk("t4_we_c8",    64'(rf_we),           64'd1);
    chk("t4_addr_c8",  64'(rf_waddr[4:0]),   64'd13);
    chk("t4_data_c8",  64'(rf_wdata[31:0]),  64'hC);
    chk("t4_pend_c8",  64'(pending),         64'h2000);
    chk("t4_ready_c8", 64'(xready),          64'd1);
    next();
    settle();
    chk("t4_pend_c9", 64'(pending), 64'd0);
    next();

    // ---------------- 5: dual push, x0 push, discarded push ----------------
    setx(1'b1, 1'b1, 1'b1, 5'd9, 32'hAAAA_0000, 32'hBBBB_0000);
    next();
    setx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t5_pend_c1", 64'(pending),  64'h300);
    chk("t5_we_c1",   64'(rf_we),    64'd3);
    chk("t5_addr_c1", 64'(rf_waddr), 64'({5'd9, 5'd8}));
    chk("t5_data_c1", rf_wdata,      {32'hBBBB_0000, 32'hAAAA_0000});
    chk("t5_dw_c1",   64'(rf_dual),  64'd1);
    next();
    settle();
    chk("t5_pend_c2", 64'(pending), 64'd0);
    setx(1'b1, 1'b1, 1'b0, 5'd0, 32'h1234, 32'h0);
    next();
    setx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t5_x0_pend", 64'(pending), 64'd0);
    chk("t5_x0_we",   64'(rf_we),   64'd0);
    next();
    setx(1'b1, 1'b0, 1'b0, 5'd6, 32'h6666, 32'h0);
    settle();
    chk("t5_nowe_ready", 64'(xready), 64'd1);
    next();
    setx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t5_nowe_pend", 64'(pending), 64'd0);
    chk("t5_nowe_we",   64'(rf_we),   64'd0);
    next();

    // ---------------- 6: reset with two entries buffered ----------------
    setwb(1'b1, 1'b1, 5'd2, 5'd3, 32'h2222, 32'h3333);
    setx(1'b1, 1'b1, 1'b0, 5'd14, 32'hE, 32'h0);
    next();
    setx(1'b1, 1'b1, 1'b0, 5'd15, 32'hF, 32'h0);
    next();
    setx(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t6_pend_full", 64'(pending), 64'hC000);
    rst = 1'b1;
    setwb(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    settle();
    chk("t6_rst_ready", 64'(xready),  64'd0);
    chk("t6_rst_pend",  64'(pending), 64'd0);
    chk("t6_rst_we",    64'(rf_we),   64'd0);
    next();
    rst = 1'b0;
    settle();
    chk("t6_post_pend",  64'(pending),  64'd0);
    chk("t6_post_stall", 64'(wb_stall), 64'd0);
    chk("t6_post_we",    64'(rf_we),    64'd0);
    chk("t6_post_ready", 64'(xready),   64'd1);
    next();
    settle();
    chk("t6_post_we2", 64'(rf_we), 64'd0);
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
